wb_lsu_master: RTL and testbench

//  Wishbone classic initiator that turns one load/store request at a time into a single
//  CYC/STB bus cycle. Sits between the core's load/store path and the Wishbone slaves
//  (block RAM, peripherals). Builds byte selects and lane-replicated write data for

---
 rtl/wb_lsu_master.sv | 151 +++++++++++++++
 tb/tb_wb_lsu_master.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/wb_lsu_master.sv
// Wishbone classic initiator: one load/store request becomes one CYC/STB cycle,
// with lane steering, load extension, alignment checking and an ack timeout.
module wb_lsu_master #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 8,
  parameter int SELECT_WIDTH = DATA_WIDTH / 8,
  parameter int TIMEOUT      = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [1:0]              req_size,
  input  logic                    req_unsigned,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic [ADDR_WIDTH-1:0]   adr_o,
  output logic [DATA_WIDTH-1:0]   dat_o,
  input  logic [DATA_WIDTH-1:0]   dat_i,
  output logic                    we_o,
  output logic [SELECT_WIDTH-1:0] sel_o,
  output logic                    stb_o,
  output logic                    cyc_o,
  input  logic                    ack_i
);

  localparam int CNT_W = $clog2(TIMEOUT + 2);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t                  state_reg;
  logic [1:0]              size_reg;
  logic                    unsigned_reg;
  logic [CNT_W-1:0]        timeout_cnt_reg;

  logic                    aligned;
  logic                    timeout_hit;
  logic [SELECT_WIDTH-1:0] sel_next;
  logic [DATA_WIDTH-1:0]   wdata_next;
  logic [DATA_WIDTH-1:0]   load_shifted;
  logic [DATA_WIDTH-1:0]   load_ext;

  assign req_ready = (state_reg == IDLE);

  always_comb begin
    case (req_size)
      2'd0:    aligned = 1'b1;
      2'd1:    aligned = ~req_addr[0];
      2'd2:    aligned = (req_addr[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
  end

  // Per-lane select and write-data steering; half selects only need addr[1]
  // because a legal half access is always 2-byte aligned.
  for (genvar gi = 0; gi < SELECT_WIDTH; gi++) begin : g_lane
    assign sel_next[gi] = (req_size == 2'd0) ? (req_addr[1:0] == 2'(gi)) :
                          (req_size == 2'd1) ? (req_addr[1] == 1'(gi / 2)) :
                                               1'b1;
    assign wdata_next[gi*8 +: 8] = (req_size == 2'd0) ? req_wdata[7:0] :
                                   (req_size == 2'd1) ? req_wdata[(gi % 2)*8 +: 8] :
                                                        req_wdata[gi*8 +: 8];
  end

  assign load_shifted = dat_i >> {adr_o[1:0], 3'b000};

  always_comb begin
    load_ext = load_shifted;
    case (size_reg)
      2'd0:    load_ext = {{(DATA_WIDTH-8){load_shifted[7] & ~unsigned_reg}}, load_shifted[7:0]};
      2'd1:    load_ext = {{(DATA_WIDTH-16){load_shifted[15] & ~unsigned_reg}}, load_shifted[15:0]};
      default: load_ext = load_shifted;
    endcase
  end

  // Fires on the cycle whose missing ack would bring the count up to TIMEOUT.
  assign timeout_hit = (TIMEOUT != 0) && (int'(timeout_cnt_reg) == TIMEOUT - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      size_reg        <= 2'd0;
      unsigned_reg    <= 1'b0;
      timeout_cnt_reg <= '0;
      rsp_valid       <= 1'b0;
      rsp_err         <= 1'b0;
      rsp_rdata       <= '0;
      adr_o           <= '0;
      dat_o           <= '0;
      we_o            <= 1'b0;
      sel_o           <= '0;
      stb_o           <= 1'b0;
      cyc_o           <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            adr_o           <= req_addr;
            we_o            <= req_we;
            sel_o           <= sel_next;
            dat_o           <= wdata_next;
            size_reg        <= req_size;
            unsigned_reg    <= req_unsigned;
            timeout_cnt_reg <= '0;
            if (aligned) begin
              cyc_o     <= 1'b1;
              stb_o     <= 1'b1;
              state_reg <= BUS;
            end else begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
              state_reg <= RESP;
            end
          end
        end
        BUS: begin
          if (!ack_i) timeout_cnt_reg <= timeout_cnt_reg + 1'b1;
          if (ack_i) begin
            cyc_o     <= 1'b0;
            stb_o     <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= we_o ? '0 : load_ext;
            state_reg <= RESP;
          end else if (timeout_hit) begin
            cyc_o     <= 1'b0;
            stb_o     <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            state_reg <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_lsu_master.sv
// Directed bench for wb_lsu_master: the bench plays the Wishbone slave and the
// response consumer, checking bus fields, cycle counts and responses.
module tb_wb_lsu_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [7:0]  adr_o;
  logic [31:0] dat_o, dat_i;
  logic        we_o, stb_o, cyc_o, ack_i;
  logic [3:0]  sel_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_lsu_master #(
    .DATA_WIDTH(32), .ADDR_WIDTH(8), .SELECT_WIDTH(4), .TIMEOUT(15)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .adr_o(adr_o), .dat_o(dat_o), .dat_i(dat_i), .we_o(we_o), .sel_o(sel_o),
    .stb_o(stb_o), .cyc_o(cyc_o), .ack_i(ack_i)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request end to end. Entered and left on a negative edge. The slave
  // acks on the ack_at-th cycle that cyc_o is seen high (0 = never acks).
  task automatic do_req(input string name, input logic we, input logic [1:0] size,
                        input logic uns, input logic [7:0] addr, input logic [31:0] wdata,
                        input int ack_at, input logic [31:0] rdata, input int exp_cyc,
                        input logic [3:0] exp_sel, input logic [31:0] exp_dat,
                        input logic exp_err, input logic [31:0] exp_rd, input int hold);
    int cyc_cnt;
    check({name, "/req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0; req_wdata = 32'h0BAD_0BAD;
    cyc_cnt = 0;
    while (cyc_o === 1'b1 && cyc_cnt < 40) begin
      cyc_cnt++;
      if (cyc_cnt == 1 || cyc_cnt == exp_cyc) begin
        check({name, "/stb"}, 32'(stb_o), 32'd1);
        check({name, "/sel"}, 32'(sel_o), 32'(exp_sel));
        check({name, "/adr"}, 32'(adr_o), 32'(addr));
        check({name, "/we"}, 32'(we_o), 32'(we));
        if (we) check({name, "/dat_o"}, dat_o, exp_dat);
      end
      ack_i = (cyc_cnt == ack_at);
      dat_i = ack_i ? rdata : 32'h5555_AAAA;
      @(negedge clk);
      ack_i = 1'b0; dat_i = 32'h0;
    end
    check({name, "/cyc_cycles"}, 32'(cyc_cnt), 32'(exp_cyc));
    check({name, "/stb_low"}, 32'(stb_o), 32'd0);
    check({name, "/rsp_valid"}, 32'(rsp_valid), 32'd1);
    check({name, "/rsp_err"}, 32'(rsp_err), 32'(exp_err));
    check({name, "/rsp_rdata"}, rsp_rdata, exp_rd);
    for (int h = 0; h < hold; h++) begin
      ack_i = 1'b1; dat_i = 32'hFFFF_FFFF;
      @(negedge clk);
      ack_i = 1'b0; dat_i = 32'h0;
      check({name, "/hold_valid"}, 32'(rsp_valid), 32'd1);
      check({name, "/hold_rdata"}, rsp_rdata, exp_rd);
      check({name, "/hold_err"}, 32'(rsp_err), 32'(exp_err));
      check({name, "/hold_req_ready"}, 32'(req_ready), 32'd0);
      check({name, "/hold_cyc"}, 32'(cyc_o), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({name, "/rsp_drop"}, 32'(rsp_valid), 32'd0);
    check({name, "/req_ready_back"}, 32'(req_ready), 32'd1);
    $display("txn %s: cyc_cycles=%0d err=%0b rdata=%h", name, cyc_cnt, exp_err, exp_rd);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 8'h0; req_wdata = 32'h0; rsp_ready = 1'b0; dat_i = 32'h0; ack_i = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("reset/req_ready", 32'(req_ready), 32'd1);
    check("reset/cyc", 32'(cyc_o), 32'd0);
    check("reset/stb", 32'(stb_o), 32'd0);
    check("reset/we", 32'(we_o), 32'd0);
    check("reset/sel", 32'(sel_o), 32'd0);
    check("reset/adr", 32'(adr_o), 32'd0);
    check("reset/dat_o", dat_o, 32'd0);
    check("reset/rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset/rsp_err", 32'(rsp_err), 32'd0);
    check("reset/rsp_rdata", rsp_rdata, 32'd0);
    $display("txn reset: done");

    // Stray ack while idle must not start anything.
    ack_i = 1'b1; dat_i = 32'h1234_5678;
    @(negedge clk);
    ack_i = 1'b0; dat_i = 32'h0;
    check("idle_ack/rsp_valid", 32'(rsp_valid), 32'd0);
    check("idle_ack/cyc", 32'(cyc_o), 32'd0);

    //     name          we    size  uns   addr   wdata          ack rdata          cyc sel      dat_o          err   rdata          hold
    do_req("st_word",    1'b1, 2'd2, 1'b0, 8'h10, 32'hDEADBEEF,  2,  32'h0,         2,  4'b1111, 32'hDEADBEEF,  1'b0, 32'h0,         0);
    do_req("ld_byte_s",  1'b0, 2'd0, 1'b0, 8'h13, 32'h0,         2,  32'h80123456,  2,  4'b1000, 32'h0,         1'b0, 32'hFFFFFF80,  0);
    do_req("ld_byte_u",  1'b0, 2'd0, 1'b1, 8'h13, 32'h0,         2,  32'h80123456,  2,  4'b1000, 32'h0,         1'b0, 32'h00000080,  0);
    do_req("st_half",    1'b1, 2'd1, 1'b0, 8'h06, 32'h1234A5C3,  2,  32'h0,         2,  4'b1100, 32'hA5C3A5C3,  1'b0, 32'h0,         0);
    do_req("ld_half_u",  1'b0, 2'd1, 1'b1, 8'h06, 32'h0,         2,  32'hA5C30000,  2,  4'b1100, 32'h0,         1'b0, 32'h0000A5C3,  0);
    do_req("ld_half_s",  1'b0, 2'd1, 1'b0, 8'h06, 32'h0,         2,  32'hA5C30000,  2,  4'b1100, 32'h0,         1'b0, 32'hFFFFA5C3,  0);
    do_req("st_byte",    1'b1, 2'd0, 1'b0, 8'h01, 32'hFFFFFF5A,  2,  32'h0,         2,  4'b0010, 32'h5A5A5A5A,  1'b0, 32'h0,         0);
    do_req("ld_word",    1'b0, 2'd2, 1'b0, 8'h04, 32'h0,         2,  32'h12345678,  2,  4'b1111, 32'h0,         1'b0, 32'h12345678,  0);
    do_req("mis_word",   1'b0, 2'd2, 1'b0, 8'h02, 32'h0,         1,  32'hFFFFFFFF,  0,  4'b0000, 32'h0,         1'b1, 32'h0,         0);
    do_req("mis_half",   1'b1, 2'd1, 1'b0, 8'h05, 32'h0000BEEF,  1,  32'h0,         0,  4'b0000, 32'h0,         1'b1, 32'h0,         0);
    do_req("ill_size",   1'b0, 2'd3, 1'b0, 8'h00, 32'h0,         1,  32'hFFFFFFFF,  0,  4'b0000, 32'h0,         1'b1, 32'h0,         0);
    do_req("timeout",    1'b0, 2'd2, 1'b0, 8'h08, 32'h0,         0,  32'h0,         15, 4'b1111, 32'h0,         1'b1, 32'h0,         0);
    do_req("ack_last",   1'b0, 2'd2, 1'b0, 8'h08, 32'h0,         15, 32'hCAFEF00D,  15, 4'b1111, 32'h0,         1'b0, 32'hCAFEF00D,  0);
    do_req("hold_resp",  1'b0, 2'd0, 1'b1, 8'h11, 32'h0,         2,  32'h0000AB00,  2,  4'b0010, 32'h0,         1'b0, 32'h000000AB,  5);

    // Reset in the middle of a bus cycle drops the request without a response.
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 8'h20;
    @(negedge clk);
    req_valid = 1'b0;
    check("rst_bus/cyc_before", 32'(cyc_o), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_bus/cyc", 32'(cyc_o), 32'd0);
    check("rst_bus/stb", 32'(stb_o), 32'd0);
    check("rst_bus/rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_bus/req_ready", 32'(req_ready), 32'd1);
    ack_i = 1'b1; dat_i = 32'h7777_7777;
    @(negedge clk);
    ack_i = 1'b0; dat_i = 32'h0;
    check("rst_bus/no_rsp", 32'(rsp_valid), 32'd0);
    $display("txn rst_bus: request dropped");

    do_req("after_rst",  1'b0, 2'd0, 1'b0, 8'h22, 32'h0,         2,  32'h00FF0000,  2,  4'b0100, 32'h0,         1'b0, 32'hFFFFFFFF,  0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
